// File: rtl/net_packet_arbiter.sv
// -----------------------------------------------------------------------------
// net_packet_arbiter
//
// Purpose:
//   Merges N_IN packet streams onto one shared network stream. Whole packets
//   are granted one at a time in round-robin order. The grant is locked from
//   the first beat of a packet until its last beat is handshaken.
//
//   The FSM has two states:
//     IDLE   - no stream is connected. A winner is chosen and registered.
//              This gives a one-cycle bubble before each packet.
//     LOCKED - the granted stream is connected straight through to the output
//              with zero latency, until the last beat completes.
//
// Ports:
//   clock          in   1          single clock
//   reset          in   1          synchronous, active-high
//   in_valid       in   N_IN       per-requester valid
//   in_ready       out  N_IN       per-requester ready
//   in_bits_data   in   64*N_IN    requester i occupies [64*i+63:64*i]
//   in_bits_last   in   N_IN       per-requester last-beat flag
//   out_valid      out  1          shared stream valid
//   out_ready      in   1          shared stream ready
//   out_bits_data  out  64         shared stream data
//   out_bits_last  out  1          shared stream last flag
//   out_src        out  SRC_W      registered grant index
//   pkt_count      out  32         completed-packet counter; only present when
//                                  NET_ARB_PKT_COUNT_EN is defined
//
// Build option:
//   NET_ARB_PKT_COUNT_EN - adds the pkt_count output and its counter.
//                          The counter wraps and resets to 0.
// -----------------------------------------------------------------------------
module net_packet_arbiter #(
    parameter int N_IN  = 4,
    parameter int SRC_W = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N_IN-1:0]      in_valid,
    output logic [N_IN-1:0]      in_ready,
    input  logic [64*N_IN-1:0]   in_bits_data,
    input  logic [N_IN-1:0]      in_bits_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [63:0]          out_bits_data,
    output logic                 out_bits_last,
    output logic [SRC_W-1:0]     out_src
`ifdef NET_ARB_PKT_COUNT_EN
    ,
    output logic [31:0]          pkt_count
`endif
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [SRC_W-1:0] grant_q, grant_d;
    logic [SRC_W-1:0] last_grant_q, last_grant_d;

    logic             locked;
    logic             hs_last;
    logic [SRC_W-1:0] winner;
    logic [SRC_W-1:0] cand;
    logic             found;

    assign locked = (state_q == LOCKED);

    // Round-robin search. It starts one past the previous packet's owner and
    // wraps modulo N_IN. The previous owner is tried last, at offset N_IN.
    always_comb begin
        winner = '0;
        cand   = '0;
        found  = 1'b0;
        for (int k = 1; k <= N_IN; k++) begin
            cand = SRC_W'((int'(last_grant_q) + k) % N_IN);
            if (!found && in_valid[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    // Zero-latency pass-through of the granted stream while locked.
    always_comb begin
        out_valid     = 1'b0;
        out_bits_data = '0;
        out_bits_last = 1'b0;
        in_ready      = '0;
        if (locked) begin
            out_valid         = in_valid[grant_q];
            out_bits_data     = in_bits_data[{grant_q, 6'b0} +: 64];
            out_bits_last     = in_bits_last[grant_q];
            in_ready[grant_q] = out_ready;
        end
    end

    assign out_src = grant_q;
    assign hs_last = out_valid & out_ready & out_bits_last;

    // A valid input that drops mid-packet does not release the lock.
    // Only the handshake of the last beat frees the output.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = winner;
                    state_d = LOCKED;
                end
            end
            default: begin
                if (hs_last) begin
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end
            end
        endcase
    end

    // Control registers. last_grant resets to N_IN-1, so requester 0 is
    // searched first after reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= SRC_W'(N_IN - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

`ifdef NET_ARB_PKT_COUNT_EN
    logic [31:0] pkt_cnt_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            pkt_cnt_q <= '0;
        end else if (hs_last) begin
            pkt_cnt_q <= pkt_cnt_q + 32'd1;
        end
    end

    assign pkt_count = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_net_packet_arbiter.sv
module tb_net_packet_arbiter;

    localparam int N_IN  = 4;
    localparam int SRC_W = 2;

    logic                 clock = 1'b0;
    logic                 reset;
    logic [N_IN-1:0]      in_valid;
    logic [N_IN-1:0]      in_ready;
    logic [64*N_IN-1:0]   in_bits_data;
    logic [N_IN-1:0]      in_bits_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [63:0]          out_bits_data;
    logic                 out_bits_last;
    logic [SRC_W-1:0]     out_src;
`ifdef NET_ARB_PKT_COUNT_EN
    logic [31:0]          pkt_count;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    net_packet_arbiter #(.N_IN(N_IN), .SRC_W(SRC_W)) dut (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_bits_data  (in_bits_data),
        .in_bits_last  (in_bits_last),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_bits_data (out_bits_data),
        .out_bits_last (out_bits_last),
        .out_src       (out_src)
`ifdef NET_ARB_PKT_COUNT_EN
        ,
        .pkt_count     (pkt_count)
`endif
    );

    function automatic logic [63:0] dat(input int port, input int beat);
        return 64'hD00D_0000_0000_0000 | (64'(port) << 8) | 64'(beat);
    endfunction

    // Inputs change 2 time units after a rising edge.
    // Outputs are checked 1 time unit later, away from any edge.
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic drive(input int port, input int beat, input logic last);
        in_bits_data[64*port +: 64] = dat(port, beat);
        in_bits_last[port]          = last;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        in_valid     = '0;
        in_bits_data = '0;
        in_bits_last = '0;
        out_ready    = 1'b0;
        tick();
        tick();
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd0);
        chk("rst_out_src",   64'(out_src),   64'd0);
        reset = 1'b0;

        // Port 0 sends a 3-beat packet.
        in_valid  = 4'b0001;
        out_ready = 1'b1;
        drive(0, 1, 1'b0);
        #1;
        chk("s1_bubble_valid", 64'(out_valid), 64'd0);
        chk("s1_bubble_ready", 64'(in_ready),  64'd0);
        tick(); #1;
        chk("s1_b1_valid", 64'(out_valid),     64'd1);
        chk("s1_b1_data",  out_bits_data,      dat(0, 1));
        chk("s1_b1_ready", 64'(in_ready),      64'b0001);
        chk("s1_b1_src",   64'(out_src),       64'd0);
        tick(); drive(0, 2, 1'b0); #1;
        chk("s1_b2_data",  out_bits_data,      dat(0, 2));
        chk("s1_b2_last",  64'(out_bits_last), 64'd0);
        tick(); drive(0, 3, 1'b1); #1;
        chk("s1_b3_data",  out_bits_data,      dat(0, 3));
        chk("s1_b3_last",  64'(out_bits_last), 64'd1);
        chk("s1_b3_src",   64'(out_src),       64'd0);
        tick(); #1;
        chk("s1_idle_valid", 64'(out_valid),   64'd0);
        chk("s1_idle_ready", 64'(in_ready),    64'd0);
        in_valid = '0;

        // All four ports hold single-beat packets. Grants rotate 0,1,2,3,0.
        do_reset();
        in_valid = 4'b1111;
        for (int p = 0; p < N_IN; p++) drive(p, 7, 1'b1);
        #1;
        chk("s2_first_idle", 64'(out_valid), 64'd0);
        begin
            int exp_g [5];
            exp_g = '{0, 1, 2, 3, 0};
            for (int i = 0; i < 5; i++) begin
                tick(); #1;
                chk($sformatf("s2_grant%0d_src",   i), 64'(out_src),   64'(exp_g[i]));
                chk($sformatf("s2_grant%0d_valid", i), 64'(out_valid), 64'd1);
                chk($sformatf("s2_grant%0d_ready", i), 64'(in_ready),  64'(1 << exp_g[i]));
                tick(); #1;
                chk($sformatf("s2_gap%0d_valid", i),   64'(out_valid), 64'd0);
            end
        end
        in_valid = '0;

        // Port 2 is locked. Port 0 requests mid-packet. out_ready goes 1,0,1.
        do_reset();
        in_valid = 4'b0100;
        drive(2, 1, 1'b0);
        tick(); #1;
        chk("s3_lock_src", 64'(out_src), 64'd2);
        in_valid = 4'b0101;
        drive(0, 9, 1'b1);
        #1;
        chk("s3_b1_ready", 64'(in_ready),  64'b0100);
        chk("s3_b1_data",  out_bits_data,  dat(2, 1));
        tick(); drive(2, 2, 1'b1); out_ready = 1'b0; #1;
        chk("s3_stall_ready", 64'(in_ready), 64'd0);
        chk("s3_stall_data",  out_bits_data, dat(2, 2));
        tick(); #1;
        chk("s3_stall2_data", out_bits_data, dat(2, 2));
        chk("s3_stall2_src",  64'(out_src),  64'd2);
        chk("s3_stall2_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        #1;
        chk("s3_resume_ready", 64'(in_ready), 64'b0100);
        tick(); in_valid = 4'b0001; #1;
        chk("s3_idle_valid", 64'(out_valid), 64'd0);
        tick(); #1;
        chk("s3_p0_src",  64'(out_src),  64'd0);
        chk("s3_p0_data", out_bits_data, dat(0, 9));
        tick(); in_valid = '0;

        // Port 1 drops valid for 2 cycles mid-packet while port 3 requests.
        in_valid = 4'b0010;
        drive(1, 1, 1'b0);
        tick(); #1;
        chk("s4_lock_src", 64'(out_src), 64'd1);
        tick(); in_valid = 4'b1000; drive(3, 5, 1'b1); #1;
        chk("s4_gap1_valid", 64'(out_valid), 64'd0);
        chk("s4_gap1_src",   64'(out_src),   64'd1);
        chk("s4_gap1_ready", 64'(in_ready),  64'b0010);
        tick(); #1;
        chk("s4_gap2_valid", 64'(out_valid), 64'd0);
        chk("s4_gap2_src",   64'(out_src),   64'd1);
        tick(); in_valid = 4'b1010; drive(1, 2, 1'b1); #1;
        chk("s4_b2_valid", 64'(out_valid),     64'd1);
        chk("s4_b2_data",  out_bits_data,      dat(1, 2));
        chk("s4_b2_last",  64'(out_bits_last), 64'd1);
        tick(); in_valid = 4'b1000; #1;
        chk("s4_idle_valid", 64'(out_valid), 64'd0);
        tick(); #1;
        chk("s4_p3_src", 64'(out_src), 64'd3);
        tick(); in_valid = '0;

        // Reset on beat 2 of a 4-beat packet from port 2.
        do_reset();
        in_valid = 4'b0100;
        drive(2, 1, 1'b0);
        tick(); #1;
        chk("s5_lock_src", 64'(out_src), 64'd2);
        tick(); drive(2, 2, 1'b0); reset = 1'b1; #1;
        chk("s5_b2_valid", 64'(out_valid), 64'd1);
        tick(); reset = 1'b0; in_valid = 4'b0101; drive(0, 4, 1'b1); #1;
        chk("s5_rst_valid", 64'(out_valid), 64'd0);
        chk("s5_rst_ready", 64'(in_ready),  64'd0);
        chk("s5_rst_src",   64'(out_src),   64'd0);
        tick(); #1;
        chk("s5_next_src",  64'(out_src),   64'd0);
        chk("s5_next_data", out_bits_data,  dat(0, 4));
        tick(); in_valid = '0;

`ifdef NET_ARB_PKT_COUNT_EN
        do_reset();
        #1;
        chk("cnt_reset", 64'(pkt_count), 64'd0);
        in_valid = 4'b0001;
        drive(0, 1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            tick();
        end
        in_valid = '0;
        #1;
        chk("cnt_five", 64'(pkt_count), 64'd5);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
